// File: rtl/if_id_stage.sv
// IF/ID pipeline stage: registered fetch address/instruction with valid/ready
// flow control, synchronous reset, flush-to-bubble and an optional skid entry.
// Define IF_ID_SKID_EN to build the two-entry variant with a registered ready_o;
// without it the stage is a single register whose ready_o follows ready_i.
module if_id_stage #(
  parameter int unsigned            ADDR_W    = 32,
  parameter int unsigned            INSTR_W   = 32,
  parameter logic [INSTR_W-1:0]     NOP_INSTR = INSTR_W'(32'h0000_0013)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic [ADDR_W-1:0]  addr_i,
  input  logic [INSTR_W-1:0] instr_i,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [ADDR_W-1:0]  addr_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic [1:0]         occ_o
);

  logic               main_valid_q, main_valid_d;
  logic [ADDR_W-1:0]  main_addr_q,  main_addr_d;
  logic [INSTR_W-1:0] main_instr_q, main_instr_d;
  logic               accept, release_e;

`ifdef IF_ID_SKID_EN
  logic               skid_valid_q, skid_valid_d;
  logic [ADDR_W-1:0]  skid_addr_q,  skid_addr_d;
  logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;

  // Ready depends only on held state, never on ready_i
  assign ready_o = ~skid_valid_q & ~rst_i;

  // Next state: main register is the output, skid absorbs one entry during a stall
  always_comb begin
    main_valid_d = main_valid_q;
    main_addr_d  = main_addr_q;
    main_instr_d = main_instr_q;
    skid_valid_d = skid_valid_q;
    skid_addr_d  = skid_addr_q;
    skid_instr_d = skid_instr_q;
    accept       = valid_i & ready_o;
    release_e    = main_valid_q & ready_i;
    if (rst_i) begin
      main_valid_d = 1'b0;
      main_addr_d  = '0;
      main_instr_d = NOP_INSTR;
      skid_valid_d = 1'b0;
      skid_addr_d  = '0;
      skid_instr_d = NOP_INSTR;
    end else if (flush_i) begin
      main_valid_d = 1'b0;
      main_instr_d = NOP_INSTR;
      skid_valid_d = 1'b0;
    end else if (skid_valid_q) begin
      if (release_e) begin
        main_addr_d  = skid_addr_q;
        main_instr_d = skid_instr_q;
        skid_valid_d = 1'b0;
      end
    end else if (main_valid_q) begin
      if (accept && release_e) begin
        main_addr_d  = addr_i;
        main_instr_d = instr_i;
      end else if (accept) begin
        skid_valid_d = 1'b1;
        skid_addr_d  = addr_i;
        skid_instr_d = instr_i;
      end else if (release_e) begin
        main_valid_d = 1'b0;
        main_instr_d = NOP_INSTR;
      end
    end else if (accept) begin
      main_valid_d = 1'b1;
      main_addr_d  = addr_i;
      main_instr_d = instr_i;
    end
  end

  // Skid storage registers
  always_ff @(posedge clk_i) begin
    skid_valid_q <= skid_valid_d;
    skid_addr_q  <= skid_addr_d;
    skid_instr_q <= skid_instr_d;
  end

  // Skid entry is only ever valid behind a valid main entry
  assign occ_o = 2'(main_valid_q) + 2'(skid_valid_q);
`else
  // Single register: a full stage can accept only when it is released this edge
  assign ready_o = (~main_valid_q | ready_i) & ~rst_i;

  // Next state for the single output register
  always_comb begin
    main_valid_d = main_valid_q;
    main_addr_d  = main_addr_q;
    main_instr_d = main_instr_q;
    accept       = valid_i & ready_o;
    release_e    = main_valid_q & ready_i;
    if (rst_i) begin
      main_valid_d = 1'b0;
      main_addr_d  = '0;
      main_instr_d = NOP_INSTR;
    end else if (flush_i) begin
      main_valid_d = 1'b0;
      main_instr_d = NOP_INSTR;
    end else if (accept) begin
      main_valid_d = 1'b1;
      main_addr_d  = addr_i;
      main_instr_d = instr_i;
    end else if (release_e) begin
      main_valid_d = 1'b0;
      main_instr_d = NOP_INSTR;
    end
  end

  assign occ_o = {1'b0, main_valid_q};
`endif

  // Main (output) register; reset is applied through the _d path
  always_ff @(posedge clk_i) begin
    main_valid_q <= main_valid_d;
    main_addr_q  <= main_addr_d;
    main_instr_q <= main_instr_d;
  end

  assign valid_o = main_valid_q;
  assign addr_o  = main_addr_q;
  assign instr_o = main_instr_q;

endmodule

// File: tb/tb_if_id_stage.sv
// Bench for if_id_stage: directed scenarios plus randomized traffic against a
// queue-based model of the stage (FIFO of capacity 1 or 2).
module tb_if_id_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef IF_ID_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i, flush_i, valid_i, ready_i;
  logic        ready_o, valid_o;
  logic [31:0] addr_i, instr_i, addr_o, instr_o;
  logic [1:0]  occ_o;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] instr;
  } entry_t;

  entry_t      mq[$];
  logic [31:0] m_last_addr;

  if_id_stage #(.ADDR_W(32), .INSTR_W(32), .NOP_INSTR(NOP)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i),
    .ready_o(ready_o), .addr_i(addr_i), .instr_i(instr_i), .valid_o(valid_o),
    .ready_i(ready_i), .addr_o(addr_o), .instr_o(instr_o), .occ_o(occ_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic cyc();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] ins);
    valid_i = v;
    addr_i  = a;
    instr_i = ins;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; flush_i = 1'b0; ready_i = 1'b1;
    drive(1'b1, $urandom, $urandom);
    #1;
    n_total++; if (ready_o !== 1'b0) $display("FAIL rst_ready_during: got %0b want 0", ready_o); else n_pass++;
    cyc();
    cyc();
    n_total++; if (valid_o !== 1'b0) $display("FAIL rst_valid: got %0b want 0", valid_o); else n_pass++;
    n_total++; if (addr_o !== 32'h0) $display("FAIL rst_addr: got %h want 0", addr_o); else n_pass++;
    n_total++; if (instr_o !== NOP) $display("FAIL rst_instr: got %h want %h", instr_o, NOP); else n_pass++;
    n_total++; if (occ_o !== 2'd0) $display("FAIL rst_occ: got %0d want 0", occ_o); else n_pass++;
    n_total++; if (ready_o !== 1'b0) $display("FAIL rst_ready_held: got %0b want 0", ready_o); else n_pass++;
    rst_i = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    #1;
    n_total++; if (ready_o !== 1'b1) $display("FAIL rst_ready_after: got %0b want 1", ready_o); else n_pass++;
  endtask

  // Stream three entries, then let the last one drain
  task automatic test_streaming();
    logic [31:0] a[3];
    logic [31:0] d[3];
    a = '{32'h0, 32'h4, 32'h8};
    d = '{32'hA, 32'hB, 32'hC};
    ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, a[i], d[i]);
      cyc();
      n_total++; if (valid_o !== 1'b1 || addr_o !== a[i] || instr_o !== d[i] || occ_o !== 2'd1)
        $display("FAIL stream_%0d: got v=%0b a=%h i=%h occ=%0d want v=1 a=%h i=%h occ=1",
                 i, valid_o, addr_o, instr_o, occ_o, a[i], d[i]);
      else n_pass++;
    end
    drive(1'b0, 32'h0, 32'h0);
    cyc();
    n_total++; if (valid_o !== 1'b0 || instr_o !== NOP || addr_o !== 32'h8 || occ_o !== 2'd0)
      $display("FAIL drain: got v=%0b a=%h i=%h occ=%0d want v=0 a=8 i=13 occ=0",
               valid_o, addr_o, instr_o, occ_o);
    else n_pass++;
  endtask

`ifdef IF_ID_SKID_EN
  // Drop ready_i while 0x0 is presented; 0x4 goes to skid, 0x8 waits upstream
  task automatic test_stall();
    ready_i = 1'b1;
    drive(1'b1, 32'h0, 32'hA);
    cyc();
    ready_i = 1'b0;
    drive(1'b1, 32'h4, 32'hB);
    cyc();
    n_total++; if (occ_o !== 2'd2 || ready_o !== 1'b0 || addr_o !== 32'h0)
      $display("FAIL stall_skid: got occ=%0d rdy=%0b a=%h want occ=2 rdy=0 a=0", occ_o, ready_o, addr_o);
    else n_pass++;
    drive(1'b1, 32'h8, 32'hC);
    cyc();
    n_total++; if (occ_o !== 2'd2 || addr_o !== 32'h0 || instr_o !== 32'hA)
      $display("FAIL stall_hold: got occ=%0d a=%h i=%h want occ=2 a=0 i=a", occ_o, addr_o, instr_o);
    else n_pass++;
    ready_i = 1'b1;
    cyc();
    n_total++; if (valid_o !== 1'b1 || addr_o !== 32'h4 || instr_o !== 32'hB || ready_o !== 1'b1 || occ_o !== 2'd1)
      $display("FAIL stall_rel1: got v=%0b a=%h i=%h rdy=%0b occ=%0d want v=1 a=4 i=b rdy=1 occ=1",
               valid_o, addr_o, instr_o, ready_o, occ_o);
    else n_pass++;
    cyc();
    drive(1'b0, 32'h0, 32'h0);
    n_total++; if (valid_o !== 1'b1 || addr_o !== 32'h8 || instr_o !== 32'hC)
      $display("FAIL stall_rel2: got v=%0b a=%h i=%h want v=1 a=8 i=c", valid_o, addr_o, instr_o);
    else n_pass++;
    cyc();
    n_total++; if (valid_o !== 1'b0 || occ_o !== 2'd0)
      $display("FAIL stall_empty: got v=%0b occ=%0d want v=0 occ=0", valid_o, occ_o);
    else n_pass++;
  endtask

  // Flush from FULL2 while 0x20 is offered
  task automatic test_flush();
    ready_i = 1'b0;
    drive(1'b1, 32'h30, 32'h1);
    cyc();
    drive(1'b1, 32'h34, 32'h2);
    cyc();
    n_total++; if (occ_o !== 2'd2) $display("FAIL flush_setup: got occ=%0d want 2", occ_o); else n_pass++;
    flush_i = 1'b1;
    drive(1'b1, 32'h20, 32'h99);
    cyc();
    flush_i = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    n_total++; if (valid_o !== 1'b0 || instr_o !== NOP || occ_o !== 2'd0 || ready_o !== 1'b1 || addr_o !== 32'h30)
      $display("FAIL flush_full2: got v=%0b i=%h occ=%0d rdy=%0b a=%h want v=0 i=13 occ=0 rdy=1 a=30",
               valid_o, instr_o, occ_o, ready_o, addr_o);
    else n_pass++;
    ready_i = 1'b1;
    cyc();
    n_total++; if (valid_o !== 1'b0 || addr_o === 32'h20)
      $display("FAIL flush_drop: got v=%0b a=%h want v=0 and a!=20", valid_o, addr_o);
    else n_pass++;
  endtask
`else
  // Combinational ready_o follows ready_i when the single register is full
  task automatic test_skid_off();
    ready_i = 1'b1;
    drive(1'b1, 32'h0, 32'hA);
    cyc();
    ready_i = 1'b0;
    drive(1'b1, 32'h4, 32'hB);
    #1;
    n_total++; if (ready_o !== 1'b0) $display("FAIL nskid_rdy_low: got %0b want 0", ready_o); else n_pass++;
    cyc();
    n_total++; if (addr_o !== 32'h0 || occ_o !== 2'd1 || valid_o !== 1'b1)
      $display("FAIL nskid_hold: got a=%h occ=%0d v=%0b want a=0 occ=1 v=1", addr_o, occ_o, valid_o);
    else n_pass++;
    ready_i = 1'b1;
    #1;
    n_total++; if (ready_o !== 1'b1) $display("FAIL nskid_rdy_high: got %0b want 1", ready_o); else n_pass++;
    cyc();
    n_total++; if (addr_o !== 32'h4 || instr_o !== 32'hB || occ_o !== 2'd1 || valid_o !== 1'b1)
      $display("FAIL nskid_acc_rel: got a=%h i=%h occ=%0d v=%0b want a=4 i=b occ=1 v=1",
               addr_o, instr_o, occ_o, valid_o);
    else n_pass++;
  endtask

  // Flush a full, stalled register while 0x20 is offered
  task automatic test_flush();
    ready_i = 1'b0;
    flush_i = 1'b1;
    drive(1'b1, 32'h20, 32'h99);
    cyc();
    flush_i = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    n_total++; if (valid_o !== 1'b0 || instr_o !== NOP || occ_o !== 2'd0 || ready_o !== 1'b1 || addr_o !== 32'h4)
      $display("FAIL flush_full: got v=%0b i=%h occ=%0d rdy=%0b a=%h want v=0 i=13 occ=0 rdy=1 a=4",
               valid_o, instr_o, occ_o, ready_o, addr_o);
    else n_pass++;
    ready_i = 1'b1;
    cyc();
    n_total++; if (valid_o !== 1'b0 || addr_o === 32'h20)
      $display("FAIL flush_drop: got v=%0b a=%h want v=0 and a!=20", valid_o, addr_o);
    else n_pass++;
  endtask
`endif

  // Random traffic checked against a FIFO model of the stage
  task automatic test_random();
    logic        exp_v, exp_rdy, rel, acc;
    logic [31:0] exp_i;
    entry_t      e;
    mq.delete();
    m_last_addr = 32'h0;
    rst_i = 1'b1; flush_i = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    cyc();
    rst_i = 1'b0;
    for (int c = 0; c < 400; c++) begin
      exp_v = (mq.size() > 0);
      exp_i = exp_v ? mq[0].instr : NOP;
      n_total++; if (valid_o !== exp_v || addr_o !== m_last_addr || instr_o !== exp_i || occ_o !== 2'(mq.size()))
        $display("FAIL rand_out c=%0d: got v=%0b a=%h i=%h occ=%0d want v=%0b a=%h i=%h occ=%0d",
                 c, valid_o, addr_o, instr_o, occ_o, exp_v, m_last_addr, exp_i, mq.size());
      else n_pass++;
      rst_i   = ($urandom_range(0, 99) < 2);
      flush_i = ($urandom_range(0, 99) < 5);
      ready_i = ($urandom_range(0, 99) < 60);
      drive(($urandom_range(0, 99) < 65), $urandom, $urandom);
      #1;
`ifdef IF_ID_SKID_EN
      exp_rdy = !rst_i && (mq.size() < CAP);
`else
      exp_rdy = !rst_i && ((mq.size() == 0) || ready_i);
`endif
      n_total++; if (ready_o !== exp_rdy)
        $display("FAIL rand_ready c=%0d: got %0b want %0b", c, ready_o, exp_rdy);
      else n_pass++;
      @(posedge clk_i);
      if (rst_i) begin
        mq.delete();
        m_last_addr = 32'h0;
      end else if (flush_i) begin
        mq.delete();
      end else begin
        rel = (mq.size() > 0) && ready_i;
        acc = valid_i && exp_rdy;
        if (rel) void'(mq.pop_front());
        if (acc) begin
          e.addr  = addr_i;
          e.instr = instr_i;
          mq.push_back(e);
        end
        if (mq.size() > 0) m_last_addr = mq[0].addr;
      end
      @(negedge clk_i);
    end
    rst_i = 1'b0; flush_i = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    test_reset();
    test_streaming();
`ifdef IF_ID_SKID_EN
    test_stall();
`else
    test_skid_off();
`endif
    test_flush();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
